// File: rtl/vx_commit_tracker.sv
// Per-warp in-flight instruction tracker for the warp scheduler.
// Counts issue/commit per warp, decodes idle/full status and sequences warp halt drains.
module vx_commit_tracker #(
    parameter int NUM_WARPS   = 4,
    parameter int ISSUE_WIDTH = 1,
    parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int CTR_WIDTH   = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_fire,
    input  logic [NW_WIDTH-1:0]           issue_wid,
    input  logic [ISSUE_WIDTH-1:0]        committed,
    input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] committed_wid,
    input  logic [ISSUE_WIDTH-1:0]        halt,
    output logic [NUM_WARPS-1:0]          warp_idle,
    output logic [NUM_WARPS-1:0]          warp_full,
    output logic [NUM_WARPS-1:0]          halt_pending,
    output logic [NUM_WARPS-1:0]          halt_done,
    output logic                          any_busy
);

    localparam int CW1 = CTR_WIDTH + 1;
    localparam logic [CTR_WIDTH-1:0] CNT_MAX = '1;

    logic [CTR_WIDTH-1:0] count_q [NUM_WARPS];
    logic [CTR_WIDTH-1:0] count_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] hp_d;
    logic [NUM_WARPS-1:0] hd_d;
    logic [NUM_WARPS-1:0] ovf;
    logic [NUM_WARPS-1:0] udf;
    logic                 hp_issue;

    // Next count per warp; sums are one bit wider so a full counter plus an issue cannot wrap.
    always_comb begin
        logic [CW1-1:0] inc;
        logic [CW1-1:0] dec;
        logic [CW1-1:0] sum;
        logic           hs;
        hp_d = '0;
        hd_d = '0;
        ovf  = '0;
        udf  = '0;
        inc  = '0;
        dec  = '0;
        sum  = '0;
        hs   = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc = CW1'(issue_fire && (issue_wid == NW_WIDTH'(w)));
            dec = '0;
            hs  = 1'b0;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (committed[i] && (committed_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w))) begin
                    dec = dec + CW1'(1);
                    if (halt[i]) begin
                        hs = 1'b1;
                    end
                end
            end
            sum    = CW1'(count_q[w]) + inc;
            udf[w] = (dec > sum);
            ovf[w] = inc[0] && (count_q[w] == CNT_MAX) && (dec == '0);
            if (udf[w]) begin
                count_d[w] = '0;
            end else if (ovf[w]) begin
                count_d[w] = CNT_MAX;
            end else begin
                count_d[w] = CTR_WIDTH'(sum - dec);
            end
            hd_d[w] = (halt_pending[w] | hs) && (count_d[w] == '0);
            hp_d[w] = (halt_pending[w] | hs) && (count_d[w] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= '0;
            end
            halt_pending <= '0;
            halt_done    <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= count_d[w];
            end
            halt_pending <= hp_d;
            halt_done    <= hd_d;
        end
    end

    always_comb begin
        warp_idle = '0;
        warp_full = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_idle[w] = (count_q[w] == '0);
            warp_full[w] = (count_q[w] == CNT_MAX);
        end
        any_busy = ~(&warp_idle);
    end

    // Scheduler contract checks: never overflow, never over-commit, never issue to a draining warp.
    assign hp_issue = issue_fire && halt_pending[issue_wid];

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) ovf == '0);
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) udf == '0);
    a_no_hp_issue:  assert property (@(posedge clk) disable iff (reset) !hp_issue);

endmodule

// File: tb/tb_vx_commit_tracker.sv
// Self-checking bench for vx_commit_tracker (4 warps, 2 commit slots).
// Directed scenarios plus legal random traffic, checked each cycle against a queue-free count model.
module tb_vx_commit_tracker;

    logic       clk;
    logic       reset;
    logic       issue_fire;
    logic [1:0] issue_wid;
    logic [1:0] committed;
    logic [3:0] committed_wid;
    logic [1:0] halt;
    logic [3:0] warp_idle;
    logic [3:0] warp_full;
    logic [3:0] halt_pending;
    logic [3:0] halt_done;
    logic       any_busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    int m_cnt [4];
    bit m_hp  [4];
    bit m_hd  [4];

    vx_commit_tracker #(
        .NUM_WARPS  (4),
        .ISSUE_WIDTH(2),
        .CTR_WIDTH  (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_fire   (issue_fire),
        .issue_wid    (issue_wid),
        .committed    (committed),
        .committed_wid(committed_wid),
        .halt         (halt),
        .warp_idle    (warp_idle),
        .warp_full    (warp_full),
        .halt_pending (halt_pending),
        .halt_done    (halt_done),
        .any_busy     (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count moves by issues minus commits; a halted warp completes when its count reaches zero.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < 4; w++) begin
                m_cnt[w] = 0;
                m_hp[w]  = 0;
                m_hd[w]  = 0;
            end
        end else begin
            for (int w = 0; w < 4; w++) begin
                int  n;
                bit  hit;
                n   = m_cnt[w];
                hit = m_hp[w];
                if (issue_fire && issue_wid == w) n = n + 1;
                for (int s = 0; s < 2; s++) begin
                    if (committed[s] && committed_wid[s*2 +: 2] == w) begin
                        n = n - 1;
                        if (halt[s]) hit = 1;
                    end
                end
                if (n < 0) n = 0;
                if (n > 63) n = 63;
                m_cnt[w] = n;
                m_hd[w]  = hit && (n == 0);
                m_hp[w]  = hit && (n != 0);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] e_idle, e_full, e_hp, e_hd;
        if (!reset && chk_en) begin
            for (int w = 0; w < 4; w++) begin
                e_idle[w] = (m_cnt[w] == 0);
                e_full[w] = (m_cnt[w] == 63);
                e_hp[w]   = m_hp[w];
                e_hd[w]   = m_hd[w];
            end
            checkOutput("warp_idle", warp_idle, e_idle);
            checkOutput("warp_full", warp_full, e_full);
            checkOutput("halt_pending", halt_pending, e_hp);
            checkOutput("halt_done", halt_done, e_hd);
            checkOutput("any_busy", any_busy, e_idle != 4'hF);
        end
    end

    task automatic applyStimulus(input bit f, input logic [1:0] wid, input logic [1:0] c,
                                 input logic [3:0] cw, input logic [1:0] h);
        @(negedge clk);
        issue_fire    = f;
        issue_wid     = wid;
        committed     = c;
        committed_wid = cw;
        halt          = h;
        @(posedge clk);
        #1;
    endtask

    task automatic issueWarp(input logic [1:0] w);
        applyStimulus(1'b1, w, 2'b00, 4'h0, 2'b00);
    endtask

    task automatic commitWarp(input logic [1:0] w, input bit h);
        applyStimulus(1'b0, 2'd0, 2'b01, {2'b00, w}, {1'b0, h});
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd0, 2'b00, 4'h0, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        issue_fire = 0; issue_wid = 0; committed = 0; committed_wid = 0; halt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1;

        idleCycles(5);
        checkOutput("rst_idle", warp_idle, 4'hF);
        checkOutput("rst_full", warp_full, 4'h0);
        checkOutput("rst_hp", halt_pending, 4'h0);
        checkOutput("rst_hd", halt_done, 4'h0);
        checkOutput("rst_busy", any_busy, 1'b0);

        issueWarp(2);
        checkOutput("w2_idle_after_issue", warp_idle, 4'b1011);
        checkOutput("w2_busy", any_busy, 1'b1);
        issueWarp(2);
        issueWarp(2);
        commitWarp(2, 0);
        commitWarp(2, 0);
        checkOutput("w2_idle_one_left", warp_idle, 4'b1011);
        commitWarp(2, 0);
        checkOutput("w2_idle_drained", warp_idle, 4'hF);
        checkOutput("w2_busy_drained", any_busy, 1'b0);

        for (int k = 0; k < 5; k++) issueWarp(1);
        applyStimulus(1'b1, 2'd1, 2'b01, 4'b0001, 2'b00);
        checkOutput("model_cnt1_net", m_cnt[1], 5);
        applyStimulus(1'b0, 2'd0, 2'b11, 4'b0101, 2'b00);
        checkOutput("model_cnt1_dual", m_cnt[1], 3);
        applyStimulus(1'b0, 2'd0, 2'b11, 4'b0101, 2'b00);
        commitWarp(1, 0);
        checkOutput("w1_idle_drained", warp_idle, 4'hF);

        for (int k = 0; k < 3; k++) issueWarp(0);
        commitWarp(0, 1);
        checkOutput("w0_hp_set", halt_pending, 4'b0001);
        checkOutput("w0_hd_early", halt_done, 4'b0000);
        commitWarp(0, 0);
        checkOutput("w0_hp_hold", halt_pending, 4'b0001);
        commitWarp(0, 0);
        checkOutput("w0_hd_pulse", halt_done, 4'b0001);
        checkOutput("w0_hp_clear", halt_pending, 4'b0000);
        idleCycles(1);
        checkOutput("w0_hd_single", halt_done, 4'b0000);

        issueWarp(3);
        commitWarp(3, 1);
        checkOutput("w3_hd_pulse", halt_done, 4'b1000);
        checkOutput("w3_hp_never", halt_pending, 4'b0000);
        idleCycles(1);
        checkOutput("w3_hd_single", halt_done, 4'b0000);

        for (int k = 0; k < 3; k++) issueWarp(2);
        commitWarp(2, 1);
        commitWarp(2, 1);
        checkOutput("w2_second_halt_absorbed", halt_done, 4'b0000);
        checkOutput("w2_hp_still", halt_pending, 4'b0100);
        commitWarp(2, 0);
        checkOutput("w2_hd_once", halt_done, 4'b0100);
        idleCycles(1);
        checkOutput("w2_hd_no_repeat", halt_done, 4'b0000);

        for (int k = 0; k < 63; k++) issueWarp(0);
        checkOutput("w0_full", warp_full, 4'b0001);
        checkOutput("model_cnt0_max", m_cnt[0], 63);
        commitWarp(0, 1);
        checkOutput("w0_not_full", warp_full, 4'b0000);
        checkOutput("w0_hp_mid_drain", halt_pending, 4'b0001);
        commitWarp(0, 0);
        #2;
        reset = 1'b1;
        issue_fire = 0; committed = 0; halt = 0;
        #1;
        checkOutput("async_rst_idle", warp_idle, 4'hF);
        checkOutput("async_rst_full", warp_full, 4'h0);
        checkOutput("async_rst_hp", halt_pending, 4'h0);
        checkOutput("async_rst_hd", halt_done, 4'h0);
        checkOutput("async_rst_busy", any_busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            int         avail [4];
            bit   [3:0] halted;
            logic [1:0] c, h, iw;
            logic [3:0] cw;
            bit         f;
            int         w;
            c = 0; h = 0; cw = 0; f = 0; iw = 0; halted = 0;
            for (int k = 0; k < 4; k++) avail[k] = m_cnt[k];
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 9) < 4) begin
                    w = $urandom_range(0, 3);
                    if (avail[w] > 0) begin
                        avail[w]--;
                        c[s] = 1'b1;
                        cw[s*2 +: 2] = 2'(w);
                        if ($urandom_range(0, 15) == 0) begin
                            h[s] = 1'b1;
                            halted[w] = 1'b1;
                        end
                    end
                end
            end
            if ($urandom_range(0, 9) < 5) begin
                w = $urandom_range(0, 3);
                if (m_cnt[w] < 63 && !m_hp[w] && !halted[w]) begin
                    f  = 1'b1;
                    iw = 2'(w);
                end
            end
            applyStimulus(f, iw, c, cw, h);
        end
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vx_commit_tracker.md
Name: VX_commit_tracker

Overview:
Scheduler-side consumer of the commit-to-scheduler signal group (committed, committed_wid, halt per issue slot). It keeps a per-warp count of in-flight instructions: increment on issue, decrement on each commit. It gives the warp scheduler per-warp idle/full status for fence, barrier and issue throttling. It latches warp halt requests and emits a one-cycle halt_done pulse once the halting warp has fully drained.

Parameters:
NUM_WARPS, 4, number of warps tracked
ISSUE_WIDTH, 1, number of commit slots per cycle
NW_WIDTH, $clog2(NUM_WARPS) (min 1), warp-id width
CTR_WIDTH, 6, in-flight counter width; max count = 2^CTR_WIDTH-1 = 63

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
issue_fire  in  1  an instruction issued this cycle
issue_wid  in  NW_WIDTH  warp of the issued instruction
committed  in  ISSUE_WIDTH  per-slot commit valid
committed_wid  in  ISSUE_WIDTH*NW_WIDTH  per-slot committing warp; slot i = bits [i*NW_WIDTH +: NW_WIDTH]
halt  in  ISSUE_WIDTH  per-slot halt request; qualified by committed[i]
warp_idle  out  NUM_WARPS  count[w]==0
warp_full  out  NUM_WARPS  count[w]==max; scheduler must not issue warp w
halt_pending  out  NUM_WARPS  halt received, drain not complete
halt_done  out  NUM_WARPS  one-cycle pulse: warp halted and drained
any_busy  out  1  OR of ~warp_idle

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values:
  - All counters 0.
  - halt_pending=0, halt_done=0.
  - Therefore warp_idle=all 1, warp_full=0, any_busy=0.
  - Reset asserted mid-operation clears all state immediately. Any in-flight or halt state is discarded.
- Per warp w, each cycle:
  - inc = issue_fire & (issue_wid==w).
  - dec = number of slots i with committed[i] & (committed_wid[i]==w). Range 0..ISSUE_WIDTH, computed at CTR_WIDTH+1 bits.
  - count_next = count + inc - dec, registered at clk.
- Simultaneous events:
  - Issue and commit to the same warp in one cycle net out. Count 5 with inc=1, dec=1 stays 5.
  - Multiple slots may commit the same warp in one cycle; all are counted.
- Boundary conditions:
  - Underflow (dec > count+inc): count saturates at 0. A simulation-only assertion fires.
  - Overflow (inc while count==max and dec==0): count holds at max. Assertion fires. The warp_full contract makes this illegal.
- Status outputs: warp_idle, warp_full and any_busy are combinational decodes of the counter registers. They reflect an event one cycle after it.
- Halt handling:
  - halt_set[w] = OR over slots of committed[i] & halt[i] & (committed_wid[i]==w).
  - hp_next = (halt_pending[w] | halt_set[w]) & ~(count_next==0).
  - halt_done[w] is registered: it is set to (halt_pending[w] | halt_set[w]) & (count_next==0).
  - Net effect: if the halting commit is the warp's last in-flight instruction, halt_done pulses in the cycle after that commit and halt_pending never asserts.
  - Otherwise halt_pending holds until the remaining commits drain. halt_done pulses the cycle after count reaches 0, and halt_pending drops in the same cycle.
- halt_done is a single-cycle pulse; it never asserts two consecutive cycles for one halt.
- A halt received while halt_pending is already set is absorbed, with no second pulse.
- issue_fire to a warp with halt_pending set is counted normally and flagged by an assertion (scheduler contract violation).
- Warps are fully independent; events for different warps in one cycle never interact.

Test Plan:
- Reset then idle 5 cycles -> warp_idle=4'b1111, warp_full=0, halt_pending=0, halt_done=0, any_busy=0.
- Issue warp 2 three times on consecutive cycles, then commit warp 2 three times -> count 1,2,3,2,1,0. warp_idle[2]=0 from the cycle after the first issue, back to 1 the cycle after the last commit. any_busy follows.
- Count[1]=5; in one cycle issue_fire wid=1 and committed wid=1 -> count stays 5. With ISSUE_WIDTH=2, both slots commit wid=1 -> count 3.
- Count[0]=3; commit wid=0 with halt=1 -> halt_pending[0]=1. Two more commits -> halt_done[0] pulses exactly one cycle after count hits 0, and halt_pending[0] clears in the same cycle.
- Count[3]=1; commit wid=3 with halt=1 -> halt_done[3]=1 next cycle only, halt_pending[3] never 1.
- Issue warp 0 63 times -> warp_full[0]=1 and count 63. Extra issue holds 63 and fires the assertion. Reset pulsed asynchronously mid-drain -> all outputs return to reset values immediately.
